// File: rtl/rf_pkg.sv
// Shared encodings and default widths for the register-file writeback path.
package rf_pkg;

   localparam int ADDR_W       = 5;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int CNT_W        = 4;

   localparam logic [4:0] REG_RA = 5'd31;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_MEM  = 2'd2,
      SRC_LINK = 2'd3
   } src_e;

endpackage

// File: rtl/rf_src_aging.sv
// Per-source wait counter: counts cycles a request sits un-granted, saturating at the limit.
module rf_src_aging #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       valid,
   input  logic       ready,
   output logic       starved,
   output logic [3:0] wait_cnt
);
   import rf_pkg::*;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] wait_cnt_q;
   logic [CNT_W-1:0] wait_cnt_d;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (reset || !valid || ready) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != LIMIT) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      wait_cnt_q <= wait_cnt_d;
   end

   assign starved  = (wait_cnt_q == LIMIT);
   assign wait_cnt = wait_cnt_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single regfile write port between LINK, MEM and ALU writeback sources,
// with aging so a waiting source is eventually promoted; also reports rs/rt write hazards.
module rf_write_arbiter #(
   parameter int DATA_W       = rf_pkg::DATA_W,
   parameter int ADDR_W       = rf_pkg::ADDR_W,
   parameter int STARVE_LIMIT = rf_pkg::STARVE_LIMIT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              link_valid,
   output logic              link_ready,
   input  logic [ADDR_W-1:0] link_addr,
   input  logic [DATA_W-1:0] link_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic [1:0]        grant_src,
   output logic              starve_evt
);
   import rf_pkg::*;

   logic       link_starved, mem_starved, alu_starved;
   logic [3:0] link_wait, mem_wait, alu_wait;
   logic       link_st_v, mem_st_v, alu_st_v;

   src_e              fixed_win, starve_win, win;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic              evt;

   logic              rf_wr_en_q, rf_wr_en_d;
   logic [ADDR_W-1:0] rf_wr_addr_q, rf_wr_addr_d;
   logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
   src_e              grant_src_q, grant_src_d;
   logic              starve_evt_q, starve_evt_d;

   rf_src_aging #(.STARVE_LIMIT(STARVE_LIMIT)) u_age_link (
      .clock(clock), .reset(reset), .valid(link_valid), .ready(link_ready),
      .starved(link_starved), .wait_cnt(link_wait)
   );
   rf_src_aging #(.STARVE_LIMIT(STARVE_LIMIT)) u_age_mem (
      .clock(clock), .reset(reset), .valid(mem_valid), .ready(mem_ready),
      .starved(mem_starved), .wait_cnt(mem_wait)
   );
   rf_src_aging #(.STARVE_LIMIT(STARVE_LIMIT)) u_age_alu (
      .clock(clock), .reset(reset), .valid(alu_valid), .ready(alu_ready),
      .starved(alu_starved), .wait_cnt(alu_wait)
   );

   // A saturated counter only counts as starved while its request is still up.
   assign link_st_v = link_starved & link_valid;
   assign mem_st_v  = mem_starved & mem_valid;
   assign alu_st_v  = alu_starved & alu_valid;

   always_comb begin
      fixed_win = SRC_NONE;
      if (link_valid)     fixed_win = SRC_LINK;
      else if (mem_valid) fixed_win = SRC_MEM;
      else if (alu_valid) fixed_win = SRC_ALU;

      starve_win = SRC_NONE;
      if (link_st_v)     starve_win = SRC_LINK;
      else if (mem_st_v) starve_win = SRC_MEM;
      else if (alu_st_v) starve_win = SRC_ALU;

      win = (starve_win != SRC_NONE) ? starve_win : fixed_win;
      if (reset) win = SRC_NONE;

      evt = !reset && (starve_win != SRC_NONE) && (starve_win != fixed_win);

      win_addr = alu_addr;
      win_data = alu_data;
      case (win)
         SRC_LINK: begin win_addr = link_addr; win_data = link_data; end
         SRC_MEM:  begin win_addr = mem_addr;  win_data = mem_data;  end
         default:  begin win_addr = alu_addr;  win_data = alu_data;  end
      endcase
   end

   assign link_ready = (win == SRC_LINK);
   assign mem_ready  = (win == SRC_MEM);
   assign alu_ready  = (win == SRC_ALU);

   always_comb begin
      rf_wr_en_d   = (win != SRC_NONE) && (win_addr != '0);
      rf_wr_addr_d = (win != SRC_NONE) ? win_addr : rf_wr_addr_q;
      rf_wr_data_d = (win != SRC_NONE) ? win_data : rf_wr_data_q;
      grant_src_d  = win;
      starve_evt_d = evt;
      if (reset) begin
         rf_wr_en_d   = 1'b0;
         rf_wr_addr_d = '0;
         rf_wr_data_d = '0;
         grant_src_d  = SRC_NONE;
         starve_evt_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      grant_src_q  <= grant_src_d;
      starve_evt_q <= starve_evt_d;
   end

   // Masking with reset kills a grant already in the output register before the
   // regfile samples it on the negedge, so a mid-operation reset issues no write.
   assign rf_wr_en   = rf_wr_en_q & ~reset;
   assign rf_wr_addr = reset ? '0 : rf_wr_addr_q;
   assign rf_wr_data = reset ? '0 : rf_wr_data_q;
   assign grant_src  = reset ? 2'd0 : grant_src_q;
   assign starve_evt = starve_evt_q & ~reset;

   assign rs_busy = (rs_addr != '0) &&
                    ((link_valid && link_addr == rs_addr) ||
                     (mem_valid  && mem_addr  == rs_addr) ||
                     (alu_valid  && alu_addr  == rs_addr) ||
                     (rf_wr_en   && rf_wr_addr == rs_addr));
   assign rt_busy = (rt_addr != '0) &&
                    ((link_valid && link_addr == rt_addr) ||
                     (mem_valid  && mem_addr  == rt_addr) ||
                     (alu_valid  && alu_addr  == rt_addr) ||
                     (rf_wr_en   && rf_wr_addr == rt_addr));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: priority, aging, r0, hazards and mid-operation reset.
module tb_rf_write_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        link_valid, mem_valid, alu_valid;
   logic        link_ready, mem_ready, alu_ready;
   logic [4:0]  link_addr, mem_addr, alu_addr;
   logic [31:0] link_data, mem_data, alu_data;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic [4:0]  rs_addr, rt_addr;
   logic        rs_busy, rt_busy;
   logic [1:0]  grant_src;
   logic        starve_evt;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   rf_write_arbiter dut (
      .clock(clock), .reset(reset),
      .link_valid(link_valid), .link_ready(link_ready), .link_addr(link_addr), .link_data(link_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .grant_src(grant_src), .starve_evt(starve_evt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      link_valid = 0; mem_valid = 0; alu_valid = 0;
      link_addr = 0;  mem_addr = 0;  alu_addr = 0;
      link_data = 0;  mem_data = 0;  alu_data = 0;
      rs_addr = 0;    rt_addr = 0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Reset state
      check("rst_wr_en", rf_wr_en, 0);
      check("rst_wr_addr", rf_wr_addr, 0);
      check("rst_wr_data", rf_wr_data, 0);
      check("rst_grant_src", grant_src, 0);
      check("rst_starve_evt", starve_evt, 0);

      // 1. ALU alone
      alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
      #1;
      check("t1_alu_ready", alu_ready, 1);
      check("t1_link_ready", link_ready, 0);
      tick();
      alu_valid = 0;
      check("t1_wr_en", rf_wr_en, 1);
      check("t1_wr_addr", rf_wr_addr, 5);
      check("t1_wr_data", rf_wr_data, 32'hDEADBEEF);
      check("t1_grant_src", grant_src, 1);

      // 2. LINK and ALU together: LINK first, ALU next cycle
      link_valid = 1; link_addr = 31; link_data = 32'h0000_0104;
      alu_valid = 1;  alu_addr = 7;   alu_data = 32'h0000_0077;
      #1;
      check("t2_link_ready", link_ready, 1);
      check("t2_alu_ready0", alu_ready, 0);
      tick();
      link_valid = 0;
      check("t2_wr_addr31", rf_wr_addr, 31);
      check("t2_wr_data_link", rf_wr_data, 32'h0000_0104);
      check("t2_grant_link", grant_src, 3);
      #1;
      check("t2_alu_ready1", alu_ready, 1);
      tick();
      alu_valid = 0;
      check("t2_wr_addr7", rf_wr_addr, 7);
      check("t2_grant_alu", grant_src, 1);
      check("t2_wr_en", rf_wr_en, 1);

      // 3. MEM back-to-back starves ALU until its counter hits 4
      mem_valid = 1; mem_addr = 12;
      alu_valid = 1; alu_addr = 3; alu_data = 32'hA5A5_0003;
      for (int i = 0; i < 4; i++) begin
         mem_data = 32'h1000 + i;
         #1;
         check("t3_mem_ready", mem_ready, 1);
         check("t3_alu_wait", alu_ready, 0);
         tick();
         check("t3_grant_mem", grant_src, 2);
         check("t3_no_evt", starve_evt, 0);
      end
      #1;
      check("t3_alu_promoted", alu_ready, 1);
      check("t3_mem_held", mem_ready, 0);
      tick();
      alu_valid = 0;
      check("t3_grant_alu", grant_src, 1);
      check("t3_starve_evt", starve_evt, 1);
      check("t3_wr_addr", rf_wr_addr, 3);
      #1;
      check("t3_mem_again", mem_ready, 1);
      tick();
      mem_valid = 0;
      check("t3_grant_mem2", grant_src, 2);
      check("t3_evt_clear", starve_evt, 0);
      check("t3_wr_data_mem", rf_wr_data, 32'h1003);
      tick();
      check("t3_idle_en", rf_wr_en, 0);
      check("t3_idle_src", grant_src, 0);
      check("t3_idle_addr_hold", rf_wr_addr, 12);
      check("t3_idle_data_hold", rf_wr_data, 32'h1003);

      // 4. Write to r0: handshake completes, no write enable
      alu_valid = 1; alu_addr = 0; alu_data = 32'h1234;
      rs_addr = 0;
      #1;
      check("t4_alu_ready", alu_ready, 1);
      check("t4_rs_busy_r0", rs_busy, 0);
      tick();
      alu_valid = 0;
      check("t4_wr_en", rf_wr_en, 0);
      check("t4_grant_src", grant_src, 1);

      // 5. Hazard tracking on a pending MEM write to r9
      link_valid = 1; link_addr = 31; link_data = 32'h200;
      mem_valid = 1;  mem_addr = 9;   mem_data = 32'h99;
      rs_addr = 9; rt_addr = 10;
      #1;
      check("t5_rs_busy_pend", rs_busy, 1);
      check("t5_rt_busy_pend", rt_busy, 0);
      check("t5_mem_wait", mem_ready, 0);
      tick();
      link_valid = 0;
      #1;
      check("t5_rs_busy_pend2", rs_busy, 1);
      check("t5_mem_ready", mem_ready, 1);
      tick();
      mem_valid = 0;
      #1;
      check("t5_wr_en", rf_wr_en, 1);
      check("t5_wr_addr", rf_wr_addr, 9);
      check("t5_rs_busy_wr", rs_busy, 1);
      check("t5_rt_busy_wr", rt_busy, 0);
      tick();
      check("t5_rs_busy_done", rs_busy, 0);
      rs_addr = 0; rt_addr = 0;

      // 6. Reset right after a grant drops the write
      alu_valid = 1; alu_addr = 6; alu_data = 32'h66;
      #1;
      check("t6_alu_ready", alu_ready, 1);
      tick();
      reset = 1;
      link_valid = 1; mem_valid = 1; alu_valid = 1;
      link_addr = 31; mem_addr = 8;  alu_addr = 6;
      #1;
      check("t6_n1_wr_en", rf_wr_en, 0);
      check("t6_n1_grant", grant_src, 0);
      check("t6_rst_link_ready", link_ready, 0);
      check("t6_rst_mem_ready", mem_ready, 0);
      check("t6_rst_alu_ready", alu_ready, 0);
      tick();
      check("t6_n2_wr_en", rf_wr_en, 0);
      check("t6_n2_grant", grant_src, 0);
      check("t6_n2_alu_ready", alu_ready, 0);
      check("t6_cnt_link", 32'(dut.u_age_link.wait_cnt_q), 0);
      check("t6_cnt_mem", 32'(dut.u_age_mem.wait_cnt_q), 0);
      check("t6_cnt_alu", 32'(dut.u_age_alu.wait_cnt_q), 0);
      link_valid = 0; mem_valid = 0; alu_valid = 0;
      reset = 0;
      tick();
      check("t6_post_wr_en", rf_wr_en, 0);
      check("t6_post_grant", grant_src, 0);
      check("t6_post_addr", rf_wr_addr, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
